// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter between N_REQ byte
// sources, sequencing the transmitter's senddata/txdone handshake per byte.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               uart_en,
  output logic               uart_senddata,
  output logic [7:0]         uart_txbyte,
  input  logic               uart_txdone,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic               done,
  output logic               timeout_err,
  output logic [15:0]        sent_count
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               en_q, en_d;
  logic               send_q, send_d;
  logic [7:0]         txbyte_q, txbyte_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               terr_q, terr_d;
  logic [15:0]        count_q, count_d;
  logic               win_found;
  logic [IDW-1:0]     win_idx;

  // Two passes: first valid at or above rr_ptr, otherwise first valid overall.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[i] && (i >= 32'(rr_ptr_q))) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= '0;
      en_q     <= 1'b0;
      send_q   <= 1'b0;
      txbyte_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      send_q   <= send_d;
      txbyte_q <= txbyte_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable && win_found) state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        if (!uart_txdone) state_d = S_WAIT;
        else if (cnt_q == CW'(TIMEOUT - 1)) state_d = S_IDLE;
      end
      S_WAIT: if (uart_txdone) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // Registered outputs are computed one cycle ahead so they line up with state_q.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    ready_d  = '0;
    en_d     = enable;
    send_d   = 1'b0;
    txbyte_d = txbyte_q;
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    terr_d   = 1'b0;
    count_d  = count_q;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_d          = win_idx;
            ready_d[win_idx] = 1'b1;
          end
        end
        S_LOAD: begin
          txbyte_d = req_data[{grant_q, 3'b000} +: 8];
          rr_ptr_d = (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
          send_d   = 1'b1;
          cnt_d    = '0;
        end
        S_SEND: begin
          cnt_d = cnt_q + 1'b1;
          if (uart_txdone) begin
            if (cnt_q == CW'(TIMEOUT - 1)) terr_d = 1'b1;
            else send_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (uart_txdone) begin
            done_d  = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign uart_en       = en_q;
  assign uart_senddata = send_q;
  assign uart_txbyte   = txbyte_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;
  assign done          = done_q;
  assign timeout_err   = terr_q;
  assign sent_count    = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: 1 bit/cycle 8N1 transmitter model, grant scoreboard,
// round-robin vector table and hand-written corner-case sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_en, uart_senddata, uart_txdone;
  logic [7:0]  uart_txbyte;
  logic        busy, done, timeout_err;
  logic [1:0]  grant_id;
  logic [15:0] sent_count;
  logic        stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_en(uart_en), .uart_senddata(uart_senddata),
    .uart_txbyte(uart_txbyte), .uart_txdone(uart_txdone), .busy(busy),
    .grant_id(grant_id), .done(done), .timeout_err(timeout_err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: start bit, 8 data bits LSB first, stop bit, then idle.
  logic       mdl_tx = 1'b1, mdl_txdone = 1'b1, mdl_busy = 1'b0;
  logic [3:0] mdl_bit = '0;
  logic [9:0] mdl_sh = '0;
  always @(posedge clk) begin
    if (!uart_en) begin
      mdl_tx <= 1'b1; mdl_txdone <= 1'b1; mdl_busy <= 1'b0; mdl_bit <= '0;
    end else if (!mdl_busy) begin
      if (uart_senddata) begin
        mdl_sh <= {1'b1, uart_txbyte, 1'b0};
        mdl_tx <= 1'b0; mdl_busy <= 1'b1; mdl_txdone <= 1'b0; mdl_bit <= 4'd1;
      end
    end else if (mdl_bit == 4'd10) begin
      mdl_txdone <= 1'b1; mdl_busy <= 1'b0; mdl_tx <= 1'b1;
    end else begin
      mdl_tx <= mdl_sh[mdl_bit]; mdl_bit <= mdl_bit + 4'd1;
    end
  end
  assign uart_txdone = stuck ? 1'b1 : mdl_txdone;

  typedef struct { int unsigned id; logic [7:0] b; } exp_t;
  typedef struct { logic [3:0] mask; logic [31:0] data; int unsigned id; logic [7:0] b; } vec_t;
  exp_t sb_q[$];
  logic [7:0] pend_b = '0;
  logic [9:0] line_q = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int unsigned id, input logic [7:0] b);
    exp_t e;
    e.id = id; e.b = b;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: grants pop expectations, done pulses check the sent byte/frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready != 4'd0) begin
        if (sb_q.size() == 0) check("unexpected_ready", 32'(req_ready), 32'd0);
        else begin
          e = sb_q.pop_front();
          check("ready_onehot", 32'(req_ready), 32'(1) << e.id);
          check("grant_id", 32'(grant_id), e.id);
          pend_b = e.b;
        end
      end
      if (done) begin
        check("txbyte", 32'(uart_txbyte), 32'(pend_b));
        check("tx_frame", 32'(line_q), 32'({1'b1, pend_b, 1'b0}));
      end
      if (done || timeout_err) check("done_terr_exclusive", 32'(done & timeout_err), 32'd0);
      if (mdl_busy) line_q = {mdl_tx, line_q[9:1]};
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 4'd0 && n < 60);
    if (req_ready == 4'd0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 100);
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic reset_checks();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_uart_en", 32'(uart_en), 32'd0);
    check("rst_senddata", 32'(uart_senddata), 32'd0);
    check("rst_txbyte", 32'(uart_txbyte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_sent_count", 32'(sent_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; stuck = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[10];
  int   t_done[5];
  int   hi_cnt, terr_cnt, d_cnt, n;

  initial begin
    vecs[0] = '{4'h1, 32'h44332210, 0, 8'h10};
    vecs[1] = '{4'h1, 32'h000000A5, 0, 8'hA5};
    vecs[2] = '{4'h9, 32'h9C0000E1, 3, 8'h9C};
    vecs[3] = '{4'hE, 32'h3B2A1900, 1, 8'h19};
    vecs[4] = '{4'h3, 32'h00007E81, 0, 8'h81};
    vecs[5] = '{4'h6, 32'h00C4B200, 1, 8'hB2};
    vecs[6] = '{4'hF, 32'hF3E2D1C0, 2, 8'hE2};
    vecs[7] = '{4'hF, 32'h0F1E2D3C, 3, 8'h0F};
    vecs[8] = '{4'h4, 32'h00660000, 2, 8'h66};
    vecs[9] = '{4'h8, 32'hFF000000, 3, 8'hFF};

    enable = 1'b1; req_valid = '0; req_data = '0;
    #1 rst = 1'b1;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("uart_en_follows", 32'(uart_en), 32'd1);

    // Single requester with latency and line pattern checks
    req_data = 32'h00000055; req_valid = 4'h1; push_exp(0, 8'h55);
    @(negedge clk);
    check("lat_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(negedge clk);
    check("lat_senddata", 32'(uart_senddata), 32'd1);
    wait_done("single");
    check("single_line", 32'(line_q), 32'h2AA);
    check("single_count", 32'(sent_count), 32'd1);
    check("single_sb_empty", 32'(sb_q.size()), 32'd0);

    // Round-robin vector table
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req_data = vecs[k].data; req_valid = vecs[k].mask;
      push_exp(vecs[k].id, vecs[k].b);
      wait_ready("vec");
      req_valid = '0;
      wait_done("vec");
      check("vec_count", 32'(sent_count), 32'(k + 1));
    end

    // Contention: 0 and 2 held continuously
    do_reset();
    req_data = 32'h00C300A1; req_valid = 4'h5;
    push_exp(0, 8'hA1); push_exp(2, 8'hC3); push_exp(0, 8'hA1); push_exp(2, 8'hC3);
    for (int k = 0; k < 4; k++) wait_done("contend");
    req_valid = '0;
    check("contend_sb_empty", 32'(sb_q.size()), 32'd0);
    check("contend_count", 32'(sent_count), 32'd4);

    // All four valid from reset, back-to-back byte period
    do_reset();
    req_data = 32'h44332211; req_valid = 4'hF;
    push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33); push_exp(3, 8'h44); push_exp(0, 8'h11);
    for (int k = 0; k < 5; k++) begin
      wait_done("all4");
      t_done[k] = cyc;
    end
    req_valid = '0;
    for (int k = 1; k < 5; k++) check("byte_period", 32'(t_done[k] - t_done[k-1]), 32'd14);
    check("all4_count", 32'(sent_count), 32'd5);
    check("all4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Stuck transmitter: timeout abort
    do_reset();
    stuck = 1'b1;
    req_data = 32'h0000005A; req_valid = 4'h1; push_exp(0, 8'h5A);
    wait_ready("stuck");
    req_valid = '0;
    hi_cnt = 0; terr_cnt = 0; d_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (uart_senddata) hi_cnt++;
      if (timeout_err) terr_cnt++;
      if (done) d_cnt++;
    end
    check("stuck_senddata_cycles", 32'(hi_cnt), 32'd16);
    check("stuck_timeout_pulses", 32'(terr_cnt), 32'd1);
    check("stuck_no_done", 32'(d_cnt), 32'd0);
    check("stuck_idle", 32'(busy), 32'd0);
    check("stuck_count", 32'(sent_count), 32'd0);
    stuck = 1'b0;

    // Enable dropped 5 cycles into WAIT
    do_reset();
    req_data = 32'h00003C00; req_valid = 4'h2; push_exp(1, 8'h3C);
    wait_ready("endrop");
    req_valid = '0;
    n = 0;
    while (!uart_senddata && n < 10) begin @(negedge clk); n++; end
    while (uart_senddata && n < 40) begin @(negedge clk); n++; end
    check("endrop_in_wait", 32'({busy, uart_senddata}), 32'h2);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    d_cnt = 0;
    @(negedge clk);
    check("endrop_uart_en", 32'(uart_en), 32'd0);
    if (done) d_cnt++;
    @(negedge clk);
    check("endrop_busy", 32'(busy), 32'd0);
    if (done) d_cnt++;
    repeat (15) begin @(negedge clk); if (done) d_cnt++; end
    check("endrop_no_done", 32'(d_cnt), 32'd0);
    check("endrop_count", 32'(sent_count), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    req_data = 32'h7E000000; req_valid = 4'h8; push_exp(3, 8'h7E);
    wait_ready("endrop_resume");
    req_valid = '0;
    wait_done("endrop_resume");
    check("endrop_resume_count", 32'(sent_count), 32'd1);

    // Async reset mid-SEND, then rr_ptr must be back at 0
    do_reset();
    req_data = 32'h00990000; req_valid = 4'h4; push_exp(2, 8'h99);
    wait_ready("midrst");
    req_valid = '0;
    @(negedge clk);
    check("midrst_in_send", 32'(uart_senddata), 32'd1);
    #1 rst = 1'b1;
    #1 reset_checks();
    @(negedge clk);
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
    req_data = 32'hD000000D; req_valid = 4'h9; push_exp(0, 8'h0D);
    wait_ready("midrst_after");
    req_valid = '0;
    wait_done("midrst_after");
    check("midrst_count", 32'(sent_count), 32'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
